// File: rtl/sync_arm_pkg.sv
// sync_arm_pkg: shared state encoding and arm register field positions
package sync_arm_pkg;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        DELAY    = 2'd2,
        PERIODIC = 2'd3
    } state_t;
    localparam int ARM_BIT        = 0;
    localparam int SWMODE_BIT     = 1;
    localparam int PERIODIC_BIT   = 2;
    localparam int DLY_LSB        = 16;
    localparam int DEFAULT_PERIOD = 1048576;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: registered rising-edge detector with synchronous reset
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);
    logic q;
    // history flop follows the input every cycle, cleared by reset
    always_ff @(posedge clk) q <= rst ? 1'b0 : d;
    assign rise = d & ~q;
endmodule

// File: rtl/sync_arm_ctrl.sv
// sync_arm_ctrl: arms on software edge, fires delayed and optionally periodic sync pulses
import sync_arm_pkg::*;
module sync_arm_ctrl #(
    parameter int PERIOD = DEFAULT_PERIOD,
    parameter int DLY_W  = 16,
    parameter int CNT_W  = 32
) (
    input  logic             user_clk,
    input  logic             user_rst,
    input  logic [31:0]      arm_reg,
    input  logic             ext_sync,
    output logic             sync_out,
    output logic             armed,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] sync_count
);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PERIOD - 1);
    state_t           cur, nxt;
    logic             arm_rise, ext_rise, trig, fire, sw_mode, pen, unused_bits;
    logic [DLY_W-1:0] dly;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    sync_edge_det u_arm (.clk(user_clk), .rst(user_rst), .d(arm_reg[ARM_BIT]), .rise(arm_rise));
    sync_edge_det u_ext (.clk(user_clk), .rst(user_rst), .d(ext_sync), .rise(ext_rise));
    assign pen         = arm_reg[PERIODIC_BIT];
    assign trig        = sw_mode | ext_rise;
    assign unused_bits = ^arm_reg[DLY_LSB-1:PERIODIC_BIT+1];
    // state register
    always_ff @(posedge user_clk) cur <= user_rst ? IDLE : nxt;
    // next state: the pulse cycle itself decides between PERIODIC and IDLE
    always_comb begin
        nxt = cur;
        case (cur)
            IDLE:     nxt = arm_rise ? ARMED : IDLE;
            ARMED:    nxt = trig ? DELAY : ARMED;
            DELAY:    nxt = sync_out ? (pen ? PERIODIC : IDLE) : DELAY;
            PERIODIC: nxt = arm_rise ? ARMED :
                            sync_out ? (pen ? PERIODIC : IDLE) :
                            (cnt == ONE && !pen) ? IDLE : PERIODIC;
            default:  nxt = IDLE;
        endcase
    end
    // outputs and counter next value; a counter value of 1 means pulse on the next edge
    always_comb begin
        armed   = cur == ARMED;
        state   = cur;
        fire    = (cur == ARMED && trig && dly == '0) ||
                  (cur == DELAY && !sync_out && cnt == ONE) ||
                  (cur == PERIODIC && !arm_rise && !sync_out && cnt == ONE && pen);
        cnt_nxt = (cur == ARMED) ? (trig ? CNT_W'(dly) : '0) :
                  (nxt == PERIODIC && sync_out) ? RELOAD :
                  (nxt inside {DELAY, PERIODIC} && cnt != '0) ? cnt - ONE : '0;
    end
    // pulse, counters and latched arm fields
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            sync_out   <= 1'b0;
            sync_count <= '0;
            cnt        <= '0;
            dly        <= '0;
            sw_mode    <= 1'b0;
        end else begin
            sync_out <= fire;
            cnt      <= cnt_nxt;
            if (sync_out) sync_count <= sync_count + ONE;
            if (arm_rise && (cur == IDLE || cur == PERIODIC)) begin
                dly     <= arm_reg[DLY_LSB +: DLY_W];
                sw_mode <= arm_reg[SWMODE_BIT];
            end
        end
    end
endmodule

// File: doc/sync_arm_ctrl.md
Name: sync_arm_ctrl

Overview:
Sequences the system sync pulse from the software-written sync-arm register, which is already resynchronised onto user_clk.
- A rising edge on the arm bit arms the block.
- The next external sync rising edge, or a software trigger, fires one sync pulse into the datapath after a programmable delay.
- The pulse can optionally repeat every PERIOD cycles.
- Status outputs go back to software readback registers.

Parameters:
PERIOD, 1048576, periodic sync interval in user_clk cycles; legal range 2 to 2^CNT_W-1.
DLY_W, 16, width of delay field taken from arm_reg[31:16].
CNT_W, 32, width of sync_count.

Ports:
user_clk  in  1  sole clock; all logic on rising edge.
user_rst  in  1  synchronous, active-high reset.
arm_reg  in  32  software register. bit0 arm; bit1 sw_mode (1 = fire without ext_sync); bit2 periodic_en; bits[31:16] delay D; other bits ignored.
ext_sync  in  1  external sync level, already synchronous to user_clk (e.g. 1PPS).
sync_out  out  1  one-cycle sync pulse to the datapath.
armed  out  1  high while waiting for a trigger (ARMED state).
state  out  2  current FSM state encoding, for debug readback.
sync_count  out  CNT_W  number of sync_out pulses since reset; wraps modulo 2^CNT_W.

Behaviour:
Reset values
- Reset asserted on any cycle: next cycle state=IDLE, sync_out=0, armed=0, sync_count=0, delay/period counters=0, edge-detect history=0.
- Reset mid-operation aborts any pending delay or period.

Edge detection
- arm_rise = arm_reg[0] & !arm_q.
- ext_rise = ext_sync & !ext_q.
- Both history flops update every non-reset cycle, in every state.

States (IDLE=0, ARMED=1, DELAY=2, PERIODIC=3)
- IDLE: arm_rise -> ARMED. Latch D = arm_reg[31:16] and sw_mode on the same cycle.
- ARMED, armed=1:
  - trigger is ext_rise when sw_mode=0; the first cycle in ARMED when sw_mode=1.
  - ext_rise on the same cycle as arm_rise is not a trigger; the block must already be in ARMED.
  - On trigger with D=0: sync_out=1 next cycle.
  - On trigger with D>0: go to DELAY, load counter with D.
  - Further arm_rise while in ARMED is ignored.
- DELAY:
  - Counter decrements each cycle; when it reaches 1, sync_out=1 next cycle.
  - Latency: trigger sampled at cycle t gives sync_out at t+1+D.
  - arm_rise during DELAY is ignored.
- After each pulse:
  - If periodic_en (sampled on the pulse cycle) = 1: go to PERIODIC and load the period counter.
  - Otherwise: go to IDLE.
- PERIODIC:
  - sync_out repeats exactly PERIOD cycles after the previous pulse while arm_reg[2]=1.
  - periodic_en low at a pulse boundary -> IDLE with no pulse.
  - arm_rise -> ARMED (re-sync), relatching D and sw_mode; the pending periodic pulse is cancelled.
- sync_out is registered, never high two consecutive cycles (PERIOD>=2).
- sync_count increments on the cycle sync_out is high, visible the following cycle.
- ext_sync is ignored outside ARMED.

Decomposition:
- Package sync_arm_pkg:
  - state enum (IDLE/ARMED/DELAY/PERIODIC);
  - arm_reg bit/field constants: ARM_BIT=0, SWMODE_BIT=1, PERIODIC_BIT=2, DLY_LSB=16;
  - default PERIOD.
- Sub-module sync_edge_det: registered rising-edge detector with synchronous reset, instantiated for arm_reg[0] and ext_sync.

Test Plan:
1. Reset, arm_reg=0x0000_0001, ext_sync pulse at cycle 20 -> sync_out high at cycle 21 only; sync_count=1; state back to IDLE; armed low from cycle 21.
2. arm_reg=0x0005_0001, ext_sync rise at t -> sync_out at t+6; no pulse at t+1..t+5.
3. arm_reg=0x0000_0003 (sw_mode), arm edge at cycle c -> sync_out at c+2 with no ext_sync activity.
4. PERIOD=8, arm_reg=0x0000_0005, ext_sync at t:
   - pulses at t+1, t+9, t+17;
   - clearing bit2 before t+25 -> no pulse at t+25, state IDLE, sync_count=3.
5. ext_sync and arm edge on same cycle -> no pulse. Later ext_sync -> one pulse. Repeated arm edges while ARMED do not change latched D.
6. user_rst asserted mid-DELAY (D=100) -> next cycle all outputs 0, state IDLE; no later pulse without a new arm edge.
